// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: 6x8 character cells fetched from a text RAM and a glyph ROM,
// serialised through a load/shift register, with a blinking block cursor and 4-clock sync delay.
module text_pixel_gen #(
  parameter int unsigned H_CELLS  = 106,
  parameter int unsigned V_CELLS  = 60,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [12:0] txt_addr,
  input  logic [7:0]  txt_data,
  output logic [10:0] rom_ad,
  output logic        rom_ce,
  output logic        rom_oce,
  input  logic [4:0]  rom_dout,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  output logic        pix_out,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out
);

  localparam logic [7:0]  COLS     = 8'(H_CELLS);
  localparam logic [6:0]  ROWS     = 7'(V_CELLS);
  localparam logic [12:0] ROW_STEP = 13'(H_CELLS);

  logic [2:0]  r_phase, w_phase_d;
  logic [7:0]  r_col, w_col_d;
  logic [2:0]  r_grow, w_grow_d;
  logic [6:0]  r_row, w_row_d;
  logic [12:0] r_row_base, w_row_base_d;
  logic [5:0]  r_frame, w_frame_d;
  logic        r_de_prev, r_vs_prev;

  logic w_vs_act, w_vs_edge, w_de_fall, w_in_range, w_next_in_range, w_cell_start, w_hit;

  // Per-cell pipeline tags, index = clocks since the cell's phase-0 clock.
  logic [3:1]  r_start, r_read, r_hit;
  logic [2:0]  r_grow1;
  logic [12:0] r_txt_addr;
  logic [10:0] r_rom_ad;
  logic        r_rom_ce;
  logic [5:0]  r_shift;
  logic        r_inv;
  logic [3:0]  r_de_dly, r_hs_dly, r_vs_dly;

  assign w_vs_act        = (vs_in == SYNC_POL);
  assign w_vs_edge       = w_vs_act & ~r_vs_prev;
  assign w_de_fall       = r_de_prev & ~de_in;
  assign w_in_range      = (r_col < COLS) && (r_row < ROWS);
  assign w_next_in_range = (w_col_d < COLS) && (w_row_d < ROWS);
  assign w_cell_start    = de_in && (r_phase == 3'd0);
  assign w_hit           = cursor_en && !r_frame[5] && w_in_range &&
                           (r_col == {1'b0, cursor_col}) && (r_row == {1'b0, cursor_row});

  always_comb begin
    w_phase_d    = r_phase;
    w_col_d      = r_col;
    w_grow_d     = r_grow;
    w_row_d      = r_row;
    w_row_base_d = r_row_base;
    w_frame_d    = r_frame;
    if (w_vs_edge) begin
      w_phase_d    = '0;
      w_col_d      = '0;
      w_grow_d     = '0;
      w_row_d      = '0;
      w_row_base_d = '0;
      w_frame_d    = r_frame + 6'd1;
    end else if (w_de_fall) begin
      w_phase_d = '0;
      w_col_d   = '0;
      w_grow_d  = r_grow + 3'd1;
      if (r_grow == 3'd7 && r_row < ROWS) begin
        w_row_d      = r_row + 7'd1;
        w_row_base_d = r_row_base + ROW_STEP;
      end
    end else if (de_in) begin
      if (r_phase == 3'd5) begin
        w_phase_d = '0;
        // Column saturates one past the last cell so overlong lines stay blank.
        if (r_col < COLS) w_col_d = r_col + 8'd1;
      end else begin
        w_phase_d = r_phase + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase    <= '0;
      r_col      <= '0;
      r_grow     <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_frame    <= '0;
      r_de_prev  <= 1'b0;
      r_vs_prev  <= 1'b0;
      r_start    <= '0;
      r_read     <= '0;
      r_hit      <= '0;
      r_grow1    <= '0;
      r_txt_addr <= '0;
      r_rom_ad   <= '0;
      r_rom_ce   <= 1'b0;
      r_shift    <= '0;
      r_inv      <= 1'b0;
      r_de_dly   <= '0;
      r_hs_dly   <= {4{~SYNC_POL}};
      r_vs_dly   <= {4{~SYNC_POL}};
    end else begin
      r_phase    <= w_phase_d;
      r_col      <= w_col_d;
      r_grow     <= w_grow_d;
      r_row      <= w_row_d;
      r_row_base <= w_row_base_d;
      r_frame    <= w_frame_d;
      r_de_prev  <= de_in;
      r_vs_prev  <= w_vs_act;
      // Address is prepared a clock early so it is valid on the cell's phase-0 clock.
      if (w_next_in_range) r_txt_addr <= w_row_base_d + 13'(w_col_d);
      r_start  <= {r_start[2:1], w_cell_start};
      r_read   <= {r_read[2:1], w_cell_start & w_in_range};
      r_hit    <= {r_hit[2:1], w_cell_start & w_hit};
      r_grow1  <= r_grow;
      r_rom_ce <= r_read[1];
      if (r_read[1]) r_rom_ad <= {txt_data, r_grow1};
      if (r_start[3]) begin
        r_shift <= r_read[3] ? {rom_dout, 1'b0} : 6'd0;
        r_inv   <= r_hit[3];
      end else begin
        r_shift <= {r_shift[4:0], 1'b0};
      end
      r_de_dly <= {r_de_dly[2:0], de_in};
      r_hs_dly <= {r_hs_dly[2:0], hs_in};
      r_vs_dly <= {r_vs_dly[2:0], vs_in};
    end
  end

  assign txt_addr = r_txt_addr;
  assign rom_ad   = r_rom_ad;
  assign rom_ce   = r_rom_ce;
  assign rom_oce  = r_rom_ce;
  assign pix_out  = r_de_dly[3] & (r_shift[5] ^ r_inv);
  assign de_out   = r_de_dly[3];
  assign hs_out   = r_hs_dly[3];
  assign vs_out   = r_vs_dly[3];

endmodule

// File: tb/tb_text_pixel_gen.sv
// Bench for text_pixel_gen: memory models plus a per-pixel reference computed from screen
// coordinates (pixel x in line, line in frame, frame count).
module tb_text_pixel_gen;
  localparam int H = 106;
  localparam int V = 60;

  logic        clk = 1'b0;
  logic        reset, de_in, hs_in, vs_in;
  logic [12:0] txt_addr;
  logic [7:0]  txt_data;
  logic [10:0] rom_ad;
  logic        rom_ce, rom_oce;
  logic [4:0]  rom_dout;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        pix_out, de_out, hs_out, vs_out;

  text_pixel_gen dut (
    .clk(clk), .reset(reset), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .txt_addr(txt_addr), .txt_data(txt_data), .rom_ad(rom_ad), .rom_ce(rom_ce),
    .rom_oce(rom_oce), .rom_dout(rom_dout), .cursor_en(cursor_en), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .pix_out(pix_out), .de_out(de_out), .hs_out(hs_out),
    .vs_out(vs_out)
  );

  always #5 clk = ~clk;

  logic [7:0] tram [0:8191];
  logic [4:0] grom [0:2047];

  always @(posedge clk) begin
    txt_data <= tram[txt_addr];
    if (rom_ce && rom_oce) rom_dout <= grom[rom_ad];
  end

  typedef struct packed {logic de; logic hs; logic vs; logic pix;} exp_t;
  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Reference state in screen terms.
  int       m_x, m_line;
  bit [5:0] m_frame;
  bit       m_de_prev, m_vs_prev, m_hit;

  // Drives one clock of inputs and queues the output expected 4 clocks later.
  task automatic step(input logic de, input logic hs, input logic vs, input logic rst);
    exp_t e;
    int col, row, ph, g;
    logic [4:0] bits;
    bit vact;
    reset = rst; de_in = de; hs_in = hs; vs_in = vs;
    if (rst) begin
      q.delete();
      e = '{de: 1'b0, hs: 1'b1, vs: 1'b1, pix: 1'b0};
      repeat (4) q.push_back(e);
      m_x = 0; m_line = 0; m_frame = '0; m_de_prev = 0; m_vs_prev = 0; m_hit = 0;
    end else begin
      e = '{de: de, hs: hs, vs: vs, pix: 1'b0};
      vact = (vs == 1'b0);
      if (de) begin
        col = m_x / 6; ph = m_x % 6; row = m_line / 8; g = m_line % 8;
        if (ph == 0)
          m_hit = cursor_en && !m_frame[5] && col == int'(cursor_col) &&
                  row == int'(cursor_row) && col < H && row < V;
        if (col < H && row < V) begin
          bits = grom[{tram[row * H + col], 3'(g)}];
          if (ph < 5) e.pix = bits[4 - ph];
          e.pix = e.pix ^ m_hit;
        end
      end
      q.push_back(e);
      if (vact && !m_vs_prev) begin
        m_x = 0; m_line = 0; m_frame = m_frame + 6'd1;
      end else if (m_de_prev && !de) begin
        m_x = 0; m_line++;
      end else if (de) begin
        m_x++;
      end
      m_de_prev = de; m_vs_prev = vact;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      step(i < 5, 1'b0, 1'b1, i < 5);
      e = q.pop_front(); total++;
      if ({de_out, hs_out, vs_out, pix_out} !== e) begin
        bad++;
        $display("FAIL reset_stream t=%0t got %b%b%b%b want %b", $time,
                 de_out, hs_out, vs_out, pix_out, e);
      end
      if (i < 5) begin
        total++;
        if ({rom_ce, rom_oce, txt_addr, rom_ad} !== 26'd0) begin
          bad++;
          $display("FAIL reset_regs got ce=%b oce=%b addr=%h ad=%h want 0", rom_ce, rom_oce,
                   txt_addr, rom_ad);
        end
      end
    end
  endtask

  task automatic test_l_lines();
    exp_t e;
    int n_de, ce_cnt, lit;
    for (int a = 0; a < 8192; a++) tram[a] = 8'h4C;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, i != 0, 1'b0);
      e = q.pop_front(); total++;
      if ({de_out, hs_out, vs_out, pix_out} !== e) begin
        bad++;
        $display("FAIL l_vs t=%0t got %b%b%b%b want %b", $time, de_out, hs_out, vs_out,
                 pix_out, e);
      end
    end
    for (int ln = 0; ln < 17; ln++) begin
      n_de = (ln < 8) ? 640 : 12;
      ce_cnt = 0; lit = 0;
      for (int k = 0; k < n_de + 16; k++) begin
        if (k == 0 && (ln == 8 || ln == 16)) begin
          total++;
          if (txt_addr !== 13'((ln / 8) * H)) begin
            bad++;
            $display("FAIL row_base line %0d got %0d want %0d", ln, txt_addr, (ln / 8) * H);
          end
        end
        if (ln == 7 && k < 636 && k % 6 == 0) begin
          total++;
          if (txt_addr !== 13'(k / 6)) begin
            bad++;
            $display("FAIL txt_addr k=%0d got %0d want %0d", k, txt_addr, k / 6);
          end
        end
        if (ln == 7 && k >= 2 && k < 638 && (k - 2) % 6 == 0) begin
          total++;
          if ({rom_ce, rom_oce, rom_ad} !== {2'b11, 11'h267}) begin
            bad++;
            $display("FAIL rom_ad k=%0d got ce=%b oce=%b ad=%h want 1 1 267", k, rom_ce,
                     rom_oce, rom_ad);
          end
        end
        ce_cnt += int'(rom_ce);
        step(k < n_de, k % 50 >= 5, 1'b1, 1'b0);
        e = q.pop_front(); total++;
        if ({de_out, hs_out, vs_out, pix_out} !== e) begin
          bad++;
          $display("FAIL l_stream line %0d k=%0d got %b%b%b%b want %b", ln, k, de_out,
                   hs_out, vs_out, pix_out, e);
        end
        if (ln == 6 && (k == 2 || k == 3)) begin
          total++;
          if ({de_out, pix_out} !== ((k == 3) ? 2'b11 : 2'b00)) begin
            bad++;
            $display("FAIL first_pixel k=%0d got de=%b pix=%b", k, de_out, pix_out);
          end
        end
        lit += int'(pix_out);
      end
      if (ln == 6 || ln == 7) begin
        total++;
        if (lit != ((ln == 6) ? 106 : 530)) begin
          bad++;
          $display("FAIL lit_count line %0d got %0d want %0d", ln, lit, (ln == 6) ? 106 : 530);
        end
      end
      if (ln == 7) begin
        total++;
        if (ce_cnt != 106) begin
          bad++;
          $display("FAIL rom_reads got %0d want 106", ce_cnt);
        end
      end
    end
  endtask

  task automatic test_cursor();
    exp_t e;
    int lit;
    for (int a = 0; a < 8192; a++) tram[a] = 8'h20;
    cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 6'd0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      void'(q.pop_front());
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < (pass == 0 ? 0 : 128); i++) begin
        step(1'b0, 1'b1, i % 4 != 0, 1'b0);
        e = q.pop_front(); total++;
        if ({de_out, hs_out, vs_out, pix_out} !== e) begin
          bad++;
          $display("FAIL cur_vs t=%0t got %b%b%b%b want %b", $time, de_out, hs_out, vs_out,
                   pix_out, e);
        end
      end
      for (int ln = 0; ln < 8; ln++) begin
        lit = 0;
        for (int k = 0; k < 42; k++) begin
          step(k < 30, 1'b1, 1'b1, 1'b0);
          e = q.pop_front(); total++;
          if ({de_out, hs_out, vs_out, pix_out} !== e) begin
            bad++;
            $display("FAIL cur_stream pass %0d line %0d k=%0d got %b%b%b%b want %b", pass, ln,
                     k, de_out, hs_out, vs_out, pix_out, e);
          end
          lit += int'(pix_out);
        end
        total++;
        if (lit != ((pass == 0) ? 6 : 0)) begin
          bad++;
          $display("FAIL cursor_lit pass %0d line %0d got %0d want %0d", pass, ln, lit,
                   (pass == 0) ? 6 : 0);
        end
      end
    end
  endtask

  task automatic test_frame_wrap();
    exp_t e;
    int lit;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 4 * ((ph == 0) ? 64 : 32); i++) begin
        step(1'b0, 1'b1, i % 4 != 0, 1'b0);
        e = q.pop_front(); total++;
        if ({de_out, hs_out, vs_out, pix_out} !== e) begin
          bad++;
          $display("FAIL wrap_vs t=%0t got %b%b%b%b want %b", $time, de_out, hs_out, vs_out,
                   pix_out, e);
        end
      end
      lit = 0;
      for (int k = 0; k < 42; k++) begin
        step(k < 30, 1'b1, 1'b1, 1'b0);
        e = q.pop_front(); total++;
        if ({de_out, hs_out, vs_out, pix_out} !== e) begin
          bad++;
          $display("FAIL wrap_stream k=%0d got %b%b%b%b want %b", k, de_out, hs_out, vs_out,
                   pix_out, e);
        end
        lit += int'(pix_out);
      end
      total++;
      if (lit != ((ph == 0) ? 0 : 6)) begin
        bad++;
        $display("FAIL frame_wrap step %0d got lit %0d want %0d", ph, lit, (ph == 0) ? 0 : 6);
      end
    end
  endtask

  task automatic test_midline_vs();
    exp_t e;
    for (int a = 0; a < 8192; a++) tram[a] = 8'($urandom);
    cursor_en = 1'b0;
    for (int ln = 0; ln < 10; ln++) begin
      for (int k = 0; k < 26; k++) begin
        step(k < 20, 1'b1, !(ln == 9 && k == 10), 1'b0);
        e = q.pop_front(); total++;
        if ({de_out, hs_out, vs_out, pix_out} !== e) begin
          bad++;
          $display("FAIL midvs_stream line %0d k=%0d got %b%b%b%b want %b", ln, k, de_out,
                   hs_out, vs_out, pix_out, e);
        end
        if (ln == 9 && k == 10) begin
          total++;
          if (txt_addr !== 13'd0) begin
            bad++;
            $display("FAIL midline_vs got txt_addr %0d want 0", txt_addr);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int n_de, n_bl, n_lines;
    bit vsp;
    for (int part = 0; part < 2; part++) begin
      n_lines = (part == 0) ? 30 : 495;
      for (int ln = 0; ln < n_lines; ln++) begin
        n_de = (part == 0) ? $urandom_range(1, 660) : $urandom_range(1, 14);
        n_bl = (part == 0) ? $urandom_range(1, 12) : $urandom_range(1, 3);
        vsp  = (part == 0) ? ($urandom_range(0, 7) == 0) : (ln == 0);
        for (int k = 0; k < n_de + n_bl; k++) begin
          if ($urandom_range(0, 15) == 0) begin
            cursor_en  = 1'($urandom_range(0, 1));
            cursor_col = 7'($urandom_range(0, (part == 0) ? 12 : 3));
            cursor_row = 6'($urandom_range(0, (part == 0) ? 4 : 63));
          end
          step(k < n_de, 1'($urandom_range(0, 1)), !(vsp && k == n_de), 1'b0);
          e = q.pop_front(); total++;
          if ({de_out, hs_out, vs_out, pix_out} !== e) begin
            bad++;
            $display("FAIL rand_stream part %0d line %0d k=%0d got %b%b%b%b want %b", part, ln,
                     k, de_out, hs_out, vs_out, pix_out, e);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midcell();
    exp_t e;
    for (int a = 0; a < 8192; a++) tram[a] = 8'h4C;
    cursor_en = 1'b0;
    for (int ln = 0; ln < 9; ln++) begin
      for (int k = 0; k < ((ln == 8) ? 60 : 14); k++) begin
        if (ln == 0) step(1'b0, 1'b1, k != 0, 1'b0);
        else if (ln < 8) step(k < 8, 1'b1, 1'b1, 1'b0);
        else step(k < 50, !(k >= 15 && k <= 20), 1'b1, k == 20);
        e = q.pop_front(); total++;
        if ({de_out, hs_out, vs_out, pix_out} !== e) begin
          bad++;
          $display("FAIL rstmid_stream line %0d k=%0d got %b%b%b%b want %b", ln, k, de_out,
                   hs_out, vs_out, pix_out, e);
        end
        if (ln == 8 && k == 20) begin
          total++;
          if ({pix_out, de_out, rom_ce, hs_out, vs_out} !== 5'b00011) begin
            bad++;
            $display("FAIL reset_midcell got pix=%b de=%b ce=%b hs=%b vs=%b want 0 0 0 1 1",
                     pix_out, de_out, rom_ce, hs_out, vs_out);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    for (int c = 0; c < 256; c++)
      for (int r = 0; r < 8; r++) grom[c * 8 + r] = 5'($urandom);
    for (int r = 0; r < 8; r++) begin
      grom[8'h4C * 8 + r] = (r == 7) ? 5'b11111 : 5'b10000;
      grom[8'h20 * 8 + r] = 5'b00000;
    end
    for (int a = 0; a < 8192; a++) tram[a] = 8'($urandom);
    test_reset();
    test_l_lines();
    test_cursor();
    test_frame_wrap();
    test_midline_vs();
    test_random();
    test_reset_midcell();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
